// File: rtl/seg_p2s_shifter_pkg.sv
// Shared constants and types for the display serial output path.
//   DataWDefault : default number of bits shifted per transfer
//   DivDefault   : default s_clk half-period in clk cycles
//   state_e      : shifter FSM state encoding
package seg_p2s_shifter_pkg;

  localparam int unsigned DataWDefault = 64;
  localparam int unsigned DivDefault   = 1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLow   = 2'd1,
    StHigh  = 2'd2,
    StLatch = 2'd3
  } state_e;

endpackage

// File: rtl/seg_edge_det.sv
// Rising-edge detector for the transfer request.
//   clk     : system clock
//   rst     : asynchronous active-high reset
//   start_i : level request, synchronous to clk
//   go_o    : high in the cycle start_i is high and was low the cycle before
module seg_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  output logic go_o
);

  logic start_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q <= 1'b0;
    end else begin
      start_q <= start_i;
    end
  end

  assign go_o = start_i & ~start_q;

endmodule

// File: rtl/seg_p2s_shifter.sv
// Parallel-to-serial output stage driving the external display shift-register chain.
// Shifts par_data MSB-first on each accepted rising edge of Start.
//   clk      : system clock
//   rst      : asynchronous active-high reset
//   Start    : transfer request, rising edge starts a transfer when idle
//   par_data : pattern to send, sampled on the accepted Start edge
//   s_clk    : serial clock, idle low, DIV cycles low then DIV cycles high per bit
//   s_out    : serial data, current shift-register MSB
//   s_pen    : latch/output enable, low while a transfer is in progress
//   s_clrn   : active-low clear to the chain, low only during/at reset
//   busy     : high from the accepted edge until the return to idle
//   done     : one-cycle pulse in the cycle busy falls
module seg_p2s_shifter
  import seg_p2s_shifter_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDefault,
  parameter int unsigned DIV    = DivDefault
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Start,
  input  logic [DATA_W-1:0] par_data,
  output logic              s_clk,
  output logic              s_out,
  output logic              s_pen,
  output logic              s_clrn,
  output logic              busy,
  output logic              done
);

  localparam int unsigned BitW = $clog2(DATA_W);
  localparam int unsigned DivW = $clog2(DIV) + 1;

  localparam logic [BitW-1:0] LastBit = BitW'(DATA_W - 1);
  localparam logic [DivW-1:0] LastDiv = DivW'(DIV - 1);

  state_e            state_q;
  logic [DATA_W-1:0] sr_q;
  logic [BitW-1:0]   bit_cnt_q;
  logic [DivW-1:0]   div_cnt_q;
  logic              go;

  seg_edge_det u_edge_det (
    .clk     (clk),
    .rst     (rst),
    .start_i (Start),
    .go_o    (go)
  );

  // Data leaves straight from the register, so it only changes when the
  // high phase ends and is stable across the following s_clk rising edge.
  assign s_out = sr_q[DATA_W-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      s_clk     <= 1'b0;
      s_pen     <= 1'b1;
      s_clrn    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      s_clrn <= 1'b1;
      done   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (go) begin
            sr_q      <= par_data;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
            s_pen     <= 1'b0;
            busy      <= 1'b1;
            state_q   <= StLow;
          end
        end
        StLow: begin
          if (div_cnt_q == LastDiv) begin
            div_cnt_q <= '0;
            s_clk     <= 1'b1;
            state_q   <= StHigh;
          end else begin
            div_cnt_q <= div_cnt_q + 1'b1;
          end
        end
        StHigh: begin
          if (div_cnt_q == LastDiv) begin
            sr_q      <= {sr_q[DATA_W-2:0], 1'b0};
            div_cnt_q <= '0;
            s_clk     <= 1'b0;
            if (bit_cnt_q == LastBit) begin
              state_q <= StLatch;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
              state_q   <= StLow;
            end
          end else begin
            div_cnt_q <= div_cnt_q + 1'b1;
          end
        end
        StLatch: begin
          state_q <= StIdle;
          s_pen   <= 1'b1;
          busy    <= 1'b0;
          done    <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_p2s_shifter.sv
module tb_seg_p2s_shifter;

  localparam int unsigned WA = 64;
  localparam int unsigned DA = 1;
  localparam int unsigned WB = 16;
  localparam int unsigned DB = 3;
  // Expected busy lengths straight from 2*DIV*DATA_W + 1.
  localparam int BusyA = 2 * DA * WA + 1;
  localparam int BusyB = 2 * DB * WB + 1;

  logic clk = 1'b0;
  logic rst;
  logic start_a, start_b;
  logic [WA-1:0] par_a;
  logic [WB-1:0] par_b;
  logic s_clk_a, s_out_a, s_pen_a, s_clrn_a, busy_a, done_a;
  logic s_clk_b, s_out_b, s_pen_b, s_clrn_b, busy_b, done_b;

  int checks = 0;
  int failures = 0;

  logic [WA-1:0] qa[$];
  logic [WB-1:0] qb[$];

  always #5 clk = ~clk;

  seg_p2s_shifter #(.DATA_W(WA), .DIV(DA)) dut_a (
    .clk(clk), .rst(rst), .Start(start_a), .par_data(par_a),
    .s_clk(s_clk_a), .s_out(s_out_a), .s_pen(s_pen_a), .s_clrn(s_clrn_a),
    .busy(busy_a), .done(done_a)
  );

  seg_p2s_shifter #(.DATA_W(WB), .DIV(DB)) dut_b (
    .clk(clk), .rst(rst), .Start(start_b), .par_data(par_b),
    .s_clk(s_clk_b), .s_out(s_out_b), .s_pen(s_pen_b), .s_clrn(s_clrn_b),
    .busy(busy_b), .done(done_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor A ----------------
  logic [WA-1:0] word_a;
  int  edges_a, blen_a;
  bit  prev_a, prev_done_a;

  always @(negedge clk) begin
    if (rst) begin
      word_a = '0; edges_a = 0; blen_a = 0; prev_a = 0; prev_done_a = 0;
      qa.delete();
    end else begin
      if (s_clk_a && !prev_a) begin
        word_a = {word_a[WA-2:0], s_out_a};
        edges_a++;
      end
      prev_a = s_clk_a;
      if (busy_a) blen_a++;
      check("a_pen_low_while_busy", s_pen_a, !busy_a);
      if (done_a) begin
        check("a_done_single", prev_done_a, 0);
        check("a_busy_at_done", busy_a, 0);
        if (qa.size() == 0) begin
          check("a_unexpected_done", 1, 0);
        end else begin
          check("a_word", word_a, qa.pop_front());
          check("a_edges", edges_a, WA);
          check("a_busy_len", blen_a, BusyA);
        end
        word_a = '0; edges_a = 0; blen_a = 0;
      end
      prev_done_a = done_a;
    end
  end

  // ---------------- monitor B ----------------
  logic [WB-1:0] word_b;
  int  edges_b, blen_b, hi_run_b, lo_run_b;
  bit  prev_b;

  always @(negedge clk) begin
    if (rst) begin
      word_b = '0; edges_b = 0; blen_b = 0; hi_run_b = 0; lo_run_b = 0; prev_b = 0;
      qb.delete();
    end else begin
      if (s_clk_b && !prev_b) begin
        word_b = {word_b[WB-2:0], s_out_b};
        edges_b++;
        check("b_low_phase", lo_run_b, DB);
        lo_run_b = 0;
      end
      if (!s_clk_b && prev_b) begin
        check("b_high_phase", hi_run_b, DB);
        hi_run_b = 0;
      end
      if (s_clk_b) hi_run_b++;
      else if (busy_b) lo_run_b++;
      prev_b = s_clk_b;
      if (busy_b) blen_b++;
      check("b_pen_low_while_busy", s_pen_b, !busy_b);
      if (done_b) begin
        if (qb.size() == 0) begin
          check("b_unexpected_done", 1, 0);
        end else begin
          check("b_word", word_b, qb.pop_front());
          check("b_edges", edges_b, WB);
          check("b_busy_len", blen_b, BusyB);
        end
        word_b = '0; edges_b = 0; blen_b = 0; lo_run_b = 0; hi_run_b = 0;
      end
    end
  end

  // Entered at a negedge; raises Start for one cycle, leaves gap negedges later.
  task automatic xfer_a(input logic [WA-1:0] d, input int gap, input bit accept);
    start_a = 1'b1;
    par_a   = d;
    if (accept) qa.push_back(d);
    @(negedge clk);
    start_a = 1'b0;
    par_a   = {$urandom, $urandom};
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic xfer_b(input logic [WB-1:0] d, input int gap, input bit accept);
    start_b = 1'b1;
    par_b   = d;
    if (accept) qb.push_back(d);
    @(negedge clk);
    start_b = 1'b0;
    par_b   = WB'($urandom);
    repeat (gap - 1) @(negedge clk);
  endtask

  initial begin
    bit hit;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; par_a = '0; par_b = '0;
    repeat (3) @(negedge clk);
    check("rst_s_clk", s_clk_a, 0);
    check("rst_s_out", s_out_a, 0);
    check("rst_s_pen", s_pen_a, 1);
    check("rst_s_clrn", s_clrn_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_b_s_clrn", s_clrn_b, 0);
    rst = 1'b0;
    @(negedge clk);
    check("clrn_high_a", s_clrn_a, 1);
    check("clrn_high_b", s_clrn_b, 1);

    // Single-bit-at-each-end pattern, then a mixed pattern.
    xfer_a(64'h8000_0000_0000_0001, 135, 1'b1);
    xfer_a(64'hA5A5_0000_FFFF_1234, 129, 1'b1);
    // This edge lands while the previous transfer is latching: ignored.
    xfer_a(64'hDEAD_BEEF_0BAD_F00D, 130, 1'b0);
    // Back-to-back: go coincides with the done cycle.
    xfer_a({$urandom, $urandom}, 130, 1'b1);
    xfer_a({$urandom, $urandom}, 135, 1'b1);

    // Start toggled every 3 cycles during a transfer.
    start_a = 1'b1;
    par_a   = 64'h0F0F_3C3C_5A5A_9999;
    qa.push_back(par_a);
    for (int i = 0; i < 30; i++) begin
      repeat (3) @(negedge clk);
      start_a = ~start_a;
      par_a   = {$urandom, $urandom};
    end
    start_a = 1'b0;
    repeat (50) @(negedge clk);
    xfer_a({$urandom, $urandom}, 135, 1'b1);

    // Start held high: one transfer only.
    start_a = 1'b1;
    par_a   = 64'h0123_4567_89AB_CDEF;
    qa.push_back(par_a);
    repeat (500) @(negedge clk);
    start_a = 1'b0;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 4; i++) xfer_a({$urandom, $urandom}, $urandom_range(130, 140), 1'b1);

    // Reset mid-transfer around bit 20.
    start_a = 1'b1;
    par_a   = {$urandom, $urandom};
    qa.push_back(par_a);
    @(negedge clk);
    start_a = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      @(negedge clk);
      #2;
      if (edges_a == 20) hit = 1'b1;
    end
    check("reach_bit20", hit, 1);
    rst = 1'b1;
    #1;
    check("midrst_s_clrn", s_clrn_a, 0);
    check("midrst_s_pen", s_pen_a, 1);
    check("midrst_s_clk", s_clk_a, 0);
    check("midrst_busy", busy_a, 0);
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    xfer_a(64'h1234_5678_9ABC_DEF0, 135, 1'b1);

    // Second instance: DATA_W=16, DIV=3.
    xfer_b(16'hBEEF, 100, 1'b1);
    xfer_b(16'h8001, 97, 1'b1);
    xfer_b(16'h5555, 98, 1'b0);
    xfer_b(WB'($urandom), 98, 1'b1);
    xfer_b(WB'($urandom), 100, 1'b1);

    repeat (20) @(negedge clk);
    check("qa_drained", qa.size(), 0);
    check("qb_drained", qb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard bound so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/seg_p2s_shifter.md
Name: seg_p2s_shifter

Overview:
- Parallel-to-serial output stage for the 7-segment/LED display path.
- Consumes the 64-bit segment pattern assembled by the display encoder. On a Start rising edge, shifts the pattern MSB-first into the board's external serial shift-register chain.
- Generates the serial clock, data, latch/output-enable and clear signals for that chain, and reports busy/done to the controller.

Parameters:
- DATA_W, 64, number of bits shifted per transfer (≥2).
- DIV, 1, half-period of s_clk in clk cycles (≥1); each s_clk phase lasts DIV clk cycles.

Ports:
- clk  input  1  system clock, all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- Start  input  1  transfer request, synchronous to clk; rising edge triggers a transfer.
- par_data  input  DATA_W  segment pattern; sampled only on the accepted Start edge.
- s_clk  output  1  serial clock to the external shift chain; idle low.
- s_out  output  1  serial data; equals current shift-register MSB.
- s_pen  output  1  display latch/output enable; low while shifting, high when idle.
- s_clrn  output  1  active-low clear to the external chain.
- busy  output  1  high from accepted edge until return to IDLE.
- done  output  1  one-cycle pulse on completion.

Behaviour:
- Reset values: s_clk=0, s_out=0, s_pen=1, s_clrn=0, busy=0, done=0, shift reg=0, counters=0, state=IDLE, start_q=0.
- After reset deasserts, s_clrn is registered high from the first clk edge and stays high.
- Edge detect: start_q <= Start every cycle; go = Start & ~start_q. Holding Start high produces one transfer only.
- States: IDLE, LOW, HIGH, LATCH.
- IDLE: s_clk=0, s_pen=1, busy=0. If go, then:
  - sr <= par_data, bit_cnt <= 0, div_cnt <= 0
  - s_pen <= 0, busy <= 1
  - state <= LOW
- LOW: s_clk=0 for DIV cycles. When div_cnt==DIV-1: div_cnt <= 0, state <= HIGH.
- HIGH: s_clk=1 for DIV cycles. When div_cnt==DIV-1:
  - sr <= {sr[DATA_W-2:0],1'b0}, div_cnt <= 0
  - If bit_cnt==DATA_W-1, state <= LATCH; otherwise bit_cnt++ and state <= LOW.
- LATCH: one cycle with s_clk=0 and s_pen=0. Next cycle: state <= IDLE, s_pen <= 1, busy <= 0, done <= 1 for exactly one cycle.
- Data timing: s_out = sr[DATA_W-1] (registered sr), so the bit is stable for the whole LOW phase and across the s_clk rising edge. Bit i (MSB=0) is sampled externally on the (i+1)-th s_clk rising edge.
- Latency: busy lasts 2·DIV·DATA_W + 1 cycles, i.e. 129 cycles at the defaults. done is asserted in the cycle busy falls.
- Start edges while busy: ignored, not queued. par_data changes while busy: ignored.
- A go in the same cycle done pulses (i.e. in IDLE) is accepted normally; back-to-back transfers are legal.
- bit_cnt width = clog2(DATA_W); div_cnt width = clog2(DIV)+1. There is no wrap beyond DATA_W-1.
- Reset mid-transfer: immediate return to reset values. s_pen goes 1, s_clrn goes 0 asynchronously, and the partially shifted external content is cleared by s_clrn.

Decomposition:
- Shared display package: DATA_W default (64), state encoding constants (IDLE/LOW/HIGH/LATCH), DIV default.
- One natural sub-module: seg_edge_det (start_q register plus rising-edge go output). Everything else stays in one module.

Test Plan:
- Reset then go, par_data=64'h8000_0000_0000_0001, DIV=1 → exactly 64 s_clk rising edges. s_out=1 at the 1st and 64th, 0 at all others. s_pen low for 129 cycles. One done pulse.
- par_data=64'hA5A5_0000_FFFF_1234 → serial bits captured at s_clk rises reassemble to 64'hA5A5_0000_FFFF_1234.
- Start toggled every 3 cycles during a transfer → still exactly 64 s_clk edges. Second transfer only after done. busy never drops early.
- Start held high 500 cycles → exactly one transfer, one done pulse.
- rst asserted at bit 20 → within the same cycle s_clrn=0, s_pen=1, s_clk=0, busy=0. After release, new Start with 64'h1234_5678_9ABC_DEF0 shifts cleanly.
- DIV=3, DATA_W=16 → s_clk high/low phases each 3 cycles. busy lasts 97 cycles. 16 rising edges.
